alu_op_issuer: RTL

Command-side initiator for the ALU function units (arithmetic, logic, compare, shift). Accepts one 4-bit opcode plus two operands over a valid/ready handshake, decodes it into a one-cycle unit enable and `ALU_FUN`, waits for the unit's registered result, and returns result, error and unit ID over a valid/ready response handshake. It sits between the command source and the four function units, with one operation in flight at a time.

---
 rtl/alu_op_issuer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_op_issuer                                                   |
// | Desc     : Single-outstanding command issuer for the ARITH/LOGIC/CMP/SHIFT |
// |            units. The optional op counter is enabled by ALU_ISSUER_OPCNT_EN.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_op_issuer #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
) (
  input  logic                      Clk,
  input  logic                      RST,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_opcode,
  input  logic [IN_DATA_WIDTH-1:0]  cmd_a,
  input  logic [IN_DATA_WIDTH-1:0]  cmd_b,
  output logic [IN_DATA_WIDTH-1:0]  A,
  output logic [IN_DATA_WIDTH-1:0]  B,
  output logic [1:0]                ALU_FUN,
  output logic                      ARITH_Enable,
  output logic                      LOGIC_Enable,
  output logic                      CMP_Enable,
  output logic                      SHIFT_Enable,
  input  logic [OUT_DATA_WIDTH-1:0] ARITH_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] LOGIC_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] SHIFT_OUT,
  input  logic                      ARITH_Flag,
  input  logic                      LOGIC_Flag,
  input  logic                      CMP_Flag,
  input  logic                      SHIFT_Flag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OUT_DATA_WIDTH-1:0] rsp_result,
  output logic [1:0]                rsp_unit,
  output logic                      rsp_err,
  output logic [15:0]               op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_cmd_ready;
  logic [IN_DATA_WIDTH-1:0]  r_a;
  logic [IN_DATA_WIDTH-1:0]  r_b;
  logic [1:0]                r_fun;
  logic [1:0]                r_sel;
  logic [3:0]                r_en;
  logic                      r_rsp_valid;
  logic [OUT_DATA_WIDTH-1:0] r_rsp_result;
  logic [1:0]                r_rsp_unit;
  logic                      r_rsp_err;

  logic [OUT_DATA_WIDTH-1:0] w_sel_out;
  logic                      w_sel_flag;
  logic                      w_rsp_fire;

  // Only the unit latched at accept time is ever observed.
  always_comb begin
    w_sel_out  = ARITH_OUT;
    w_sel_flag = ARITH_Flag;
    case (r_sel)
      2'b01: begin
        w_sel_out  = LOGIC_OUT;
        w_sel_flag = LOGIC_Flag;
      end
      2'b10: begin
        w_sel_out  = CMP_OUT;
        w_sel_flag = CMP_Flag;
      end
      2'b11: begin
        w_sel_out  = SHIFT_OUT;
        w_sel_flag = SHIFT_Flag;
      end
      default: begin
        w_sel_out  = ARITH_OUT;
        w_sel_flag = ARITH_Flag;
      end
    endcase
  end

  assign w_rsp_fire = (r_state == RESP) && rsp_ready;

  // cmd_ready is held low during reset and rises on the first edge after release.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_fun        <= '0;
      r_sel        <= '0;
      r_en         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_unit   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_cmd_ready) begin
            r_cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_fun       <= cmd_opcode[1:0];
            r_sel       <= cmd_opcode[3:2];
            r_en        <= 4'b0001 << cmd_opcode[3:2];
            r_cmd_ready <= 1'b0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_en    <= '0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_rsp_result <= w_sel_out;
          r_rsp_err    <= ~w_sel_flag;
          r_rsp_unit   <= r_sel;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_en        <= '0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUER_OPCNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_op_count <= '0;
    end else if (w_rsp_fire) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`else
  assign op_count = 16'd0;
`endif

  assign cmd_ready    = r_cmd_ready;
  assign A            = r_a;
  assign B            = r_b;
  assign ALU_FUN      = r_fun;
  assign ARITH_Enable = r_en[0];
  assign LOGIC_Enable = r_en[1];
  assign CMP_Enable   = r_en[2];
  assign SHIFT_Enable = r_en[3];
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_unit     = r_rsp_unit;
  assign rsp_err      = r_rsp_err;

endmodule
`default_nettype wire
